// File: rtl/iconn_shared_port_arb.sv
// N-requester arbiter for one shared interconnect port (round-robin or fixed priority).
// Optional downstream watchdog enabled by defining ICONN_ARB_WDOG_EN.
module iconn_shared_port_arb #(
    parameter int N_REQ     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int RESP_W    = 8,
    parameter int MODE_RR   = 1,
    parameter int WDOG_CYC  = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*PAYLOAD_W-1:0] payload_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic [N_REQ*RESP_W-1:0]    resp_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       valid_o,
    output logic [PAYLOAD_W-1:0]       payload_o,
    input  logic                       ack_i,
    input  logic [RESP_W-1:0]          resp_i,
    output logic                       err_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        win;
    logic [IW-1:0]        nxt_ptr;
    logic [IW-1:0]        cidx;
    logic [CW-1:0]        cand;
    logic                 found;
    logic [N_REQ-1:0]     win_oh;
    logic [PAYLOAD_W-1:0] win_payload;

    // Search starts at ptr in RR mode, at 0 in fixed-priority mode.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        cidx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (MODE_RR != 0) ? ({1'b0, ptr} + CW'(i)) : CW'(i);
            if (cand >= CW'(N_REQ))
                cand = cand - CW'(N_REQ);
            cidx = cand[IW-1:0];
            if (!found && req_i[cidx]) begin
                found = 1'b1;
                win   = cidx;
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    assign nxt_ptr     = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign win_payload = payload_i[int'(win)*PAYLOAD_W +: PAYLOAD_W];

`ifdef ICONN_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wcnt;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            ack_o     <= '0;
            resp_o    <= '0;
            grant_o   <= '0;
            valid_o   <= 1'b0;
            payload_o <= '0;
`ifdef ICONN_ARB_WDOG_EN
            wcnt      <= '0;
            err_o     <= 1'b0;
`endif
        end else begin
            ack_o <= '0;
`ifdef ICONN_ARB_WDOG_EN
            err_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        grant_o   <= win_oh;
                        owner     <= win;
                        payload_o <= win_payload;
                        valid_o   <= 1'b1;
                        state     <= BUSY;
                        if (MODE_RR != 0)
                            ptr <= nxt_ptr;
`ifdef ICONN_ARB_WDOG_EN
                        wcnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (ack_i) begin
                        resp_o[int'(owner)*RESP_W +: RESP_W] <= resp_i;
                        ack_o   <= grant_o;
                        valid_o <= 1'b0;
                        state   <= RESP;
                    end
`ifdef ICONN_ARB_WDOG_EN
                    // Expiry completes the owner with a zero response.
                    else if (wcnt == WW'(WDOG_CYC - 1)) begin
                        resp_o[int'(owner)*RESP_W +: RESP_W] <= '0;
                        ack_o   <= grant_o;
                        valid_o <= 1'b0;
                        err_o   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: begin
                    grant_o <= '0;
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iconn_shared_port_arb.sv
// Directed bench for iconn_shared_port_arb: RR and fixed-priority instances, N_REQ=4.
// Watchdog checks follow ICONN_ARB_WDOG_EN.
module tb_iconn_shared_port_arb;

    logic        clk = 1'b0;
    logic        resetn;

    logic [3:0]  rr_req, rr_ack, rr_grant;
    logic [63:0] rr_pay;
    logic [31:0] rr_resp;
    logic        rr_valid, rr_ack_i, rr_err;
    logic [15:0] rr_pout;
    logic [7:0]  rr_resp_i;

    logic [3:0]  fp_req, fp_ack, fp_grant;
    logic [63:0] fp_pay;
    logic [31:0] fp_resp;
    logic        fp_valid, fp_ack_i, fp_err;
    logic [15:0] fp_pout;
    logic [7:0]  fp_resp_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_resp;

    always #5 clk = ~clk;

    iconn_shared_port_arb #(
        .N_REQ(4), .PAYLOAD_W(16), .RESP_W(8), .MODE_RR(1), .WDOG_CYC(16)
    ) u_rr (
        .clk(clk), .resetn(resetn), .req_i(rr_req), .payload_i(rr_pay),
        .ack_o(rr_ack), .resp_o(rr_resp), .grant_o(rr_grant),
        .valid_o(rr_valid), .payload_o(rr_pout), .ack_i(rr_ack_i),
        .resp_i(rr_resp_i), .err_o(rr_err)
    );

    iconn_shared_port_arb #(
        .N_REQ(4), .PAYLOAD_W(16), .RESP_W(8), .MODE_RR(0), .WDOG_CYC(16)
    ) u_fp (
        .clk(clk), .resetn(resetn), .req_i(fp_req), .payload_i(fp_pay),
        .ack_o(fp_ack), .resp_o(fp_resp), .grant_o(fp_grant),
        .valid_o(fp_valid), .payload_o(fp_pout), .ack_i(fp_ack_i),
        .resp_i(fp_resp_i), .err_o(fp_err)
    );

    typedef struct {
        logic [3:0]  req;
        logic [63:0] pay;
        int          dly;
        logic [7:0]  resp;
        logic [3:0]  egrant;
        logic [15:0] epay;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic upd_resp(input logic [3:0] g, input logic [7:0] r);
        for (int k = 0; k < 4; k++)
            if (g[k]) exp_resp[k*8 +: 8] = r;
    endtask

    // One full transaction on the RR instance, entered and left in IDLE.
    task automatic rr_txn(input vec_t v, input string nm);
        rr_req = v.req;
        rr_pay = v.pay;
        cyc();
        chk({nm, " grant"}, 64'(rr_grant), 64'(v.egrant));
        chk({nm, " valid"}, 64'(rr_valid), 64'd1);
        chk({nm, " payload"}, 64'(rr_pout), 64'(v.epay));
        for (int i = 0; i < v.dly; i++) begin
            cyc();
            chk({nm, " wait valid"}, 64'(rr_valid), 64'd1);
        end
        rr_ack_i  = 1'b1;
        rr_resp_i = v.resp;
        cyc();
        rr_ack_i  = 1'b0;
        rr_resp_i = 8'hEE;
        upd_resp(v.egrant, v.resp);
        chk({nm, " ack_o"}, 64'(rr_ack), 64'(v.egrant));
        chk({nm, " valid drop"}, 64'(rr_valid), 64'd0);
        chk({nm, " resp_o"}, 64'(rr_resp), 64'(exp_resp));
        rr_req = '0;
        cyc();
        chk({nm, " ack end"}, 64'(rr_ack), 64'd0);
        chk({nm, " grant end"}, 64'(rr_grant), 64'd0);
    endtask

    logic [3:0] rr_seq[4];
    logic [3:0] fp_rq[5];
    logic [3:0] fp_ex[5];
    vec_t       dv;

    initial begin
        vt[0] = '{4'b0001, 64'h0000_0000_0000_00A5, 2, 8'h03, 4'b0001, 16'h00A5};
        vt[1] = '{4'b0011, 64'h4444_3333_2222_1111, 0, 8'h11, 4'b0010, 16'h2222};
        vt[2] = '{4'b1010, 64'hD3D3_C2C2_B1B1_A0A0, 1, 8'h22, 4'b1000, 16'hD3D3};
        vt[3] = '{4'b1010, 64'hD3D3_C2C2_B1B1_A0A0, 0, 8'h33, 4'b0010, 16'hB1B1};
        vt[4] = '{4'b0101, 64'h0404_0303_0202_0101, 3, 8'h44, 4'b0100, 16'h0303};
        vt[5] = '{4'b0001, 64'h0404_0303_0202_0101, 0, 8'h55, 4'b0001, 16'h0101};
        vt[6] = '{4'b1111, 64'hFFFF_EEEE_DDDD_CCCC, 1, 8'h66, 4'b0010, 16'hDDDD};
        vt[7] = '{4'b1001, 64'h9999_8888_7777_6666, 0, 8'h77, 4'b1000, 16'h9999};
        rr_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        fp_rq  = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b1100};
        fp_ex  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};

        resetn    = 1'b0;
        rr_req    = '0;  rr_pay = '0;  rr_ack_i = 1'b0;  rr_resp_i = '0;
        fp_req    = '0;  fp_pay = '0;  fp_ack_i = 1'b0;  fp_resp_i = '0;
        exp_resp  = '0;
        repeat (2) @(negedge clk);

        chk("rst valid", 64'(rr_valid), 64'd0);
        chk("rst grant", 64'(rr_grant), 64'd0);
        chk("rst ack", 64'(rr_ack), 64'd0);
        chk("rst resp", 64'(rr_resp), 64'd0);
        chk("rst payload", 64'(rr_pout), 64'd0);
        chk("rst err", 64'(rr_err), 64'd0);
        chk("rst fp valid", 64'(fp_valid), 64'd0);
        chk("rst fp grant", 64'(fp_grant), 64'd0);
        chk("rst fp err", 64'(fp_err), 64'd0);

        resetn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++)
            rr_txn(vt[v], $sformatf("vec%0d", v));

        // Held requests with immediate ack: one grant every 3 cycles.
        rr_req    = 4'b0011;
        rr_pay    = 64'h0000_0000_5151_5050;
        rr_ack_i  = 1'b1;
        rr_resp_i = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("b2b grant%0d", i), 64'(rr_grant), 64'(rr_seq[i]));
            cyc();
            upd_resp(rr_seq[i], 8'h5A);
            chk($sformatf("b2b ack%0d", i), 64'(rr_ack), 64'(rr_seq[i]));
            chk($sformatf("b2b resp%0d", i), 64'(rr_resp), 64'(exp_resp));
            if (i == 3) begin
                rr_req   = '0;
                rr_ack_i = 1'b0;
            end
            cyc();
            chk($sformatf("b2b idle%0d", i), 64'(rr_grant), 64'd0);
        end

        // ack_i while idle must be ignored.
        rr_ack_i  = 1'b1;
        rr_resp_i = 8'hFF;
        cyc();
        rr_ack_i  = 1'b0;
        chk("idle ack_i ack_o", 64'(rr_ack), 64'd0);
        chk("idle ack_i resp", 64'(rr_resp), 64'(exp_resp));
        chk("idle ack_i valid", 64'(rr_valid), 64'd0);

        // Fixed priority: requester 1 waits until requester 0 drops.
        fp_pay    = 64'h0000_CCCC_BBBB_AAAA;
        fp_ack_i  = 1'b1;
        fp_resp_i = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            fp_req = fp_rq[i];
            cyc();
            chk($sformatf("fp grant%0d", i), 64'(fp_grant), 64'(fp_ex[i]));
            cyc();
            chk($sformatf("fp ack%0d", i), 64'(fp_ack), 64'(fp_ex[i]));
            fp_req = '0;
            cyc();
        end
        fp_ack_i = 1'b0;
        chk("fp payload last", 64'(fp_pout), 64'h0000_0000_0000_CCCC);

        // Reset in BUSY: ptr was 2 before, must restart at 0.
        rr_req = 4'b0010;
        rr_pay = 64'h0000_0000_1234_0000;
        cyc();
        chk("rstbusy grant", 64'(rr_grant), 64'b0010);
        cyc();
        resetn = 1'b0;
        #1;
        chk("rstbusy valid", 64'(rr_valid), 64'd0);
        chk("rstbusy grant0", 64'(rr_grant), 64'd0);
        chk("rstbusy ack", 64'(rr_ack), 64'd0);
        chk("rstbusy err", 64'(rr_err), 64'd0);
        chk("rstbusy resp", 64'(rr_resp), 64'd0);
        exp_resp = '0;
        rr_req   = '0;
        @(negedge clk);
        resetn = 1'b1;
        dv = '{4'b1001, 64'hB333_0000_0000_B000, 0, 8'h12, 4'b0001, 16'hB000};
        rr_txn(dv, "post rst");

        // Long stall with req dropped mid-BUSY.
        rr_req = 4'b0001;
        rr_pay = 64'h0000_0000_0000_0F0F;
        cyc();
        chk("stall valid1", 64'(rr_valid), 64'd1);
        for (int k = 2; k <= 16; k++) begin
            cyc();
            if (k == 5) rr_req = '0;
            chk($sformatf("stall valid%0d", k), 64'(rr_valid), 64'd1);
            chk($sformatf("stall pay%0d", k), 64'(rr_pout), 64'h0F0F);
        end
`ifdef ICONN_ARB_WDOG_EN
        cyc();
        upd_resp(4'b0001, 8'h00);
        chk("wdog valid", 64'(rr_valid), 64'd0);
        chk("wdog ack", 64'(rr_ack), 64'b0001);
        chk("wdog err", 64'(rr_err), 64'd1);
        chk("wdog resp", 64'(rr_resp), 64'(exp_resp));
        rr_ack_i  = 1'b1;
        rr_resp_i = 8'hAB;
        cyc();
        rr_ack_i  = 1'b0;
        chk("wdog late ack", 64'(rr_ack), 64'd0);
        chk("wdog err end", 64'(rr_err), 64'd0);
        chk("wdog grant end", 64'(rr_grant), 64'd0);
        chk("wdog late resp", 64'(rr_resp), 64'(exp_resp));
`else
        for (int k = 17; k <= 20; k++) begin
            cyc();
            chk($sformatf("nowd valid%0d", k), 64'(rr_valid), 64'd1);
            chk($sformatf("nowd err%0d", k), 64'(rr_err), 64'd0);
        end
        rr_ack_i  = 1'b1;
        rr_resp_i = 8'h99;
        cyc();
        rr_ack_i  = 1'b0;
        upd_resp(4'b0001, 8'h99);
        chk("nowd ack", 64'(rr_ack), 64'b0001);
        chk("nowd resp", 64'(rr_resp), 64'(exp_resp));
        chk("nowd err", 64'(rr_err), 64'd0);
        cyc();
        chk("nowd ack end", 64'(rr_ack), 64'd0);
        chk("nowd grant end", 64'(rr_grant), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
